// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetcher.
//   - Default widths for the PC/memory address and the instruction word.
//   - Width and type of the byte issue/receive/outstanding counters.
//   - Fetcher state encoding.
package inst_fetcher_pkg;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_INST_WIDTH     = 32;
  localparam int DEF_BYTES_PER_INST = DEF_INST_WIDTH / 8;

  // Counters only need to reach BYTES_PER_INST (4).
  localparam int CNT_WIDTH = 3;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/inst_fetcher_byte_asm.sv
// Little-endian byte assembler for one instruction word.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             empty the buffer and restart at lane 0
//   wr_en, wr_data    write one returned byte into the next lane
//   word_next         buffered word with the incoming byte already merged
//   count             number of lanes written so far (receive count)
module inst_byte_assembler
  import inst_fetcher_pkg::*;
#(
  parameter int BYTES = DEF_BYTES_PER_INST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic [BYTES*8-1:0] word_next,
  output cnt_t               count
);

  logic [BYTES*8-1:0] word;

  // Merge the incoming byte combinationally so the top can capture the
  // completed word on the same edge the last byte arrives.
  always_comb begin
    word_next = word;
    for (int i = 0; i < BYTES; i++) begin
      if (wr_en && (count == cnt_t'(i))) begin
        word_next[i*8 +: 8] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (wr_en && (count < cnt_t'(BYTES))) begin
      word  <= word_next;
      count <= count + cnt_t'(1);
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: reads one instruction byte by byte through an
// arbitrated, pipelined memory port, assembles it little-endian and holds it
// for the IF/ID register while stalling the PC during the fetch.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pc                       fetch address from the PC register
//   flush                    redirect; abort the current fetch
//   id_stall                 downstream cannot take the instruction
//   mem_req, mem_addr        byte read request and its address
//   mem_gnt                  arbiter accepted the request this cycle
//   mem_rvalid, mem_rdata    in-order byte response
//   inst, inst_pc            assembled instruction and its address
//   inst_valid               inst/inst_pc valid, held until accepted
//   if_stall                 freeze the PC while high
//
// state | meaning
// IDLE  | latch pc, clear byte buffer, start requesting next cycle
// FETCH | issue byte reads (pipelined), collect responses
// HOLD  | instruction presented, wait for id_stall low
// DRAIN | after a flush, swallow responses still in flight
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int INST_WIDTH     = DEF_INST_WIDTH,
  parameter int BYTES_PER_INST = DEF_BYTES_PER_INST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  input  logic                  id_stall,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [7:0]            mem_rdata,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  output logic                  if_stall
);

  localparam cnt_t NBYTES    = cnt_t'(BYTES_PER_INST);
  localparam cnt_t LAST_BYTE = cnt_t'(BYTES_PER_INST - 1);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  cnt_t                  issue_cnt;
  cnt_t                  out_cnt;
  cnt_t                  recv_cnt;
  cnt_t                  issue_next;
  cnt_t                  out_next;
  logic                  gnt_fire;
  logic                  rsp_fire;
  logic                  lane_wr;
  logic                  word_done;
  logic                  asm_clear;
  logic [INST_WIDTH-1:0] word_next;

  assign gnt_fire = mem_req && mem_gnt;

  // A response is only honoured when one is actually owed; stray rvalid
  // pulses (including anything that predates a reset) are dropped.
  assign rsp_fire = mem_rvalid && (out_cnt != '0) &&
                    ((state == FETCH) || (state == DRAIN));

  assign issue_next = issue_cnt + cnt_t'(gnt_fire);
  // A grant in the same cycle as a flush is still owed a response.
  assign out_next   = out_cnt + cnt_t'(gnt_fire) - cnt_t'(rsp_fire);

  assign lane_wr   = rsp_fire && (state == FETCH);
  assign word_done = lane_wr && (recv_cnt == LAST_BYTE);
  assign asm_clear = (state == IDLE);

  // Combinational so the PC is released in the very cycle the instruction
  // is accepted.
  assign if_stall = (state != HOLD) || id_stall;

  inst_byte_assembler #(
    .BYTES (BYTES_PER_INST)
  ) u_byte_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .wr_en     (lane_wr),
    .wr_data   (mem_rdata),
    .word_next (word_next),
    .count     (recv_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= '0;
      issue_cnt  <= '0;
      out_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else if (flush) begin
      mem_req    <= 1'b0;
      inst_valid <= 1'b0;
      issue_cnt  <= '0;
      out_cnt    <= out_next;
      state      <= (out_next != '0) ? DRAIN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          fetch_pc  <= pc;
          mem_addr  <= pc;
          mem_req   <= 1'b1;
          issue_cnt <= '0;
          out_cnt   <= '0;
          state     <= FETCH;
        end
        FETCH: begin
          issue_cnt <= issue_next;
          out_cnt   <= out_next;
          mem_req   <= (issue_next < NBYTES);
          if (gnt_fire && (issue_next < NBYTES)) begin
            mem_addr <= fetch_pc + ADDR_WIDTH'(issue_next);
          end
          if (word_done) begin
            inst       <= word_next;
            inst_pc    <= fetch_pc;
            inst_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            inst_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        DRAIN: begin
          out_cnt <= out_next;
          if (out_next == '0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
